// File: rtl/uart_buffered_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_buffered_tx
// Summary  : 8N1 UART transmitter fed by a power-of-2 FIFO with a valid/ready
//            write port. Define UART_BUFFERED_TX_PARITY_EN for 8E1 framing.
// Revision : 1.0
// ============================================================================
module uart_buffered_tx #(
    parameter int CLK_HZ       = 24_000_000,
    parameter int BIT_RATE     = 115200,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          wr_valid,
    input  logic [PAYLOAD_BITS-1:0]       wr_data,
    output logic                          wr_ready,
    output logic                          uart_txd,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int c_BAUD_W         = $clog2(c_CYCLES_PER_BIT + 1);
    localparam int c_AW             = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W          = c_AW + 1;
    localparam int c_BIT_MAX        = (PAYLOAD_BITS > STOP_BITS) ? PAYLOAD_BITS : STOP_BITS;
    localparam int c_BIT_W          = $clog2(c_BIT_MAX) + 1;

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(c_CYCLES_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0]  c_LAST_DATA = c_BIT_W'(PAYLOAD_BITS - 1);
    localparam logic [c_BIT_W-1:0]  c_LAST_STOP = c_BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_BUFFERED_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    logic [PAYLOAD_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]         r_wr_ptr;
    logic [c_AW-1:0]         r_rd_ptr;
    logic [c_CNT_W-1:0]      r_count;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [c_BAUD_W-1:0]     r_baud;
    logic [c_BIT_W-1:0]      r_bit;
    logic [PAYLOAD_BITS-1:0] r_shift;
    logic                    r_txd;
    logic                    r_busy;
`ifdef UART_BUFFERED_TX_PARITY_EN
    logic                    r_parity;
`endif

    logic                    w_push;
    logic                    w_pop;
    logic                    w_has_data;
    logic                    w_baud_last;
    logic                    w_txd_line;
    logic [PAYLOAD_BITS-1:0] w_head;

    // Readiness looks only at the registered count so it never depends on a same-cycle pop.
    assign wr_ready    = (r_count != c_CNT_W'(FIFO_DEPTH));
    assign w_push      = wr_valid && wr_ready;
    assign w_has_data  = (r_count != '0);
    assign w_baud_last = (r_baud == c_BAUD_LAST);
    assign w_head      = r_mem[r_rd_ptr];

    assign uart_txd    = r_txd;
    assign tx_busy     = r_busy;
    assign fifo_count  = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_txd_line   = 1'b1;
        tx_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_has_data) begin
                    w_pop        = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_txd_line = 1'b0;
                if (w_baud_last) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_txd_line = r_shift[0];
                if (w_baud_last && (r_bit == c_LAST_DATA)) begin
`ifdef UART_BUFFERED_TX_PARITY_EN
                    w_state_next = S_PARITY;
`else
                    w_state_next = S_STOP;
`endif
                end
            end
`ifdef UART_BUFFERED_TX_PARITY_EN
            S_PARITY: begin
                w_txd_line = r_parity;
                if (w_baud_last) begin
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_baud_last && (r_bit == c_LAST_STOP)) begin
                    tx_done = 1'b1;
                    // Chain straight into the next start bit when more data is waiting.
                    if (w_has_data) begin
                        w_pop        = 1'b1;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
`ifdef UART_BUFFERED_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != S_IDLE);
            // The line register trails the state by one cycle, giving a glitch-free output.
            r_txd   <= w_txd_line;

            if (w_state_next != r_state) begin
                r_baud <= '0;
                r_bit  <= '0;
            end else if (r_state != S_IDLE) begin
                if (w_baud_last) begin
                    r_baud <= '0;
                    r_bit  <= r_bit + c_BIT_W'(1);
                    if (r_state == S_DATA) begin
                        r_shift <= r_shift >> 1;
                    end
                end else begin
                    r_baud <= r_baud + c_BAUD_W'(1);
                end
            end

            if (w_pop) begin
                r_shift <= w_head;
`ifdef UART_BUFFERED_TX_PARITY_EN
                r_parity <= ^w_head;
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_buffered_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_buffered_tx
// Summary  : Self-checking bench for uart_buffered_tx: a frame-level model is
//            compared every cycle, plus directed literal checks and a line decoder.
// Revision : 1.0
// ============================================================================
module tb_uart_buffered_tx;

    localparam int CLK_HZ     = 24_000_000;
    localparam int BIT_RATE   = 115200;
    localparam int STOP_BITS  = 1;
    localparam int FIFO_DEPTH = 16;
    localparam int CPB        = CLK_HZ / BIT_RATE;
`ifdef UART_BUFFERED_TX_PARITY_EN
    localparam int PAR        = 1;
    localparam int FRAME_LIT  = 2288;
`else
    localparam int PAR        = 0;
    localparam int FRAME_LIT  = 2080;
`endif
    localparam int NBITS      = 1 + 8 + PAR + STOP_BITS;
    localparam int FRAME      = NBITS * CPB;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic       uart_txd;
    logic       tx_busy;
    logic       tx_done;
    logic [4:0] fifo_count;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int done_cnt = 0;
    int done_t[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    uart_buffered_tx dut (
        .clk        (clk),
        .resetn     (resetn),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .uart_txd   (uart_txd),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a byte queue plus the position inside the frame on the line.
    logic [7:0]       mq[$];
    bit               m_active = 1'b0;
    int               m_pos = 0;
    logic [NBITS-1:0] m_frame = '1;
    logic             e_txd = 1'b1;
    logic             e_busy = 1'b0;
    logic             e_done = 1'b0;
    int               e_count = 0;

    function automatic logic [NBITS-1:0] build_frame(input logic [7:0] d);
        logic [NBITS-1:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
        if (PAR != 0) f[9] = ^d;
        return f;
    endfunction

    initial begin : model
        bit         do_push;
        logic [7:0] pd;
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                mq.delete();
                m_active = 1'b0;
                m_pos    = 0;
                e_txd    = 1'b1;
            end else begin
                do_push = wr_valid && (mq.size() != FIFO_DEPTH);
                pd      = wr_data;
                e_txd   = m_active ? m_frame[m_pos / CPB] : 1'b1;
                if (m_active && m_pos != FRAME - 1) begin
                    m_pos = m_pos + 1;
                end else if (mq.size() != 0) begin
                    m_frame  = build_frame(mq.pop_front());
                    m_active = 1'b1;
                    m_pos    = 0;
                end else begin
                    m_active = 1'b0;
                end
                if (do_push) mq.push_back(pd);
            end
            e_busy  = m_active;
            e_done  = m_active && (m_pos == FRAME - 1);
            e_count = mq.size();
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            cyc_n = cyc_n + 1;
            chk("cycle{txd,busy,done,ready,count}",
                {23'd0, uart_txd, tx_busy, tx_done, wr_ready, fifo_count},
                {23'd0, e_txd, e_busy, e_done, (e_count != FIFO_DEPTH), 5'(e_count)});
            if (tx_done) begin
                done_cnt = done_cnt + 1;
                done_t.push_back(cyc_n);
            end
        end
    end

    initial begin : rx_decoder
        logic       prev;
        logic [7:0] b;
        prev = 1'b1;
        b    = 8'h00;
        forever begin
            @(negedge clk);
            if (resetn && prev && !uart_txd) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = uart_txd;
                end
                if (PAR != 0) repeat (CPB) @(negedge clk);
                repeat (CPB) @(negedge clk);
                rx_q.push_back(b);
                prev = 1'b1;
            end else begin
                prev = uart_txd;
            end
        end
    end

    task automatic push1(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        @(negedge clk);
        while ((tx_busy || fifo_count != 0) && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("idle_reached", {tx_busy, fifo_count}, 32'd0);
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while (!tx_done && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("done_seen", tx_done, 32'd1);
    endtask

    task automatic chk_rx();
        chk("rx_len", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk("rx_byte", rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin : stim
        repeat (3) @(negedge clk);
        chk("rst_txd", uart_txd, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", wr_ready, 1);
        resetn = 1'b1;
        @(negedge clk);

        // Single byte 0xA5
        done_cnt = 0;
        push1(8'hA5);
        chk("s_count_N", fifo_count, 1);
        chk("s_busy_N", tx_busy, 0);
        @(negedge clk);
        chk("s_busy_N1", tx_busy, 1);
        chk("s_txd_N1", uart_txd, 1);
        chk("s_count_N1", fifo_count, 0);
        @(negedge clk);
        chk("s_txd_N2", uart_txd, 0);
        repeat (207) @(negedge clk);
        chk("s_start_end", uart_txd, 0);
        @(negedge clk);
        chk("s_bit0", uart_txd, 1);
        repeat (208) @(negedge clk);
        chk("s_bit1", uart_txd, 0);
        repeat (FRAME_LIT - 418) @(negedge clk);
        chk("s_done", tx_done, 1);
        chk("s_done_busy", tx_busy, 1);
        @(negedge clk);
        chk("s_after_done", tx_done, 0);
        chk("s_after_busy", tx_busy, 0);
        chk("s_done_cnt", done_cnt, 1);
        exp_q = '{8'hA5};
        chk_rx();

        // Back-to-back frames
        done_cnt = 0;
        done_t.delete();
        wr_valid = 1'b1;
        wr_data = 8'h00; @(negedge clk);
        wr_data = 8'hFF; @(negedge clk);
        wr_data = 8'h55; @(negedge clk);
        wr_valid = 1'b0;
        wait_idle(4 * FRAME);
        chk("b2b_done_cnt", done_cnt, 3);
        if (done_t.size() == 3) begin
            chk("b2b_gap1", done_t[1] - done_t[0], FRAME_LIT);
            chk("b2b_gap2", done_t[2] - done_t[1], FRAME_LIT);
        end
        exp_q = '{8'h00, 8'hFF, 8'h55};
        chk_rx();

        // Full FIFO: 0x01..0x14 offered, 0x01..0x11 accepted
        wr_valid = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            wr_data = 8'(i);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        chk("full_count", fifo_count, 16);
        chk("full_ready", wr_ready, 0);
        wait_done(FRAME + 20);
        @(negedge clk);
        chk("full_ready_back", wr_ready, 1);
        chk("full_count_15", fifo_count, 15);
        wait_idle(17 * FRAME);
        for (int i = 1; i <= 17; i++) exp_q.push_back(8'(i));
        chk_rx();

        // Push on the pop edge at a frame boundary
        push1(8'h81);
        @(negedge clk);
        push1(8'h42);
        chk("sim_count_pre", fifo_count, 1);
        wait_done(FRAME + 20);
        chk("sim_count_at_done", fifo_count, 1);
        push1(8'h7E);
        chk("sim_count_post", fifo_count, 1);
        chk("sim_busy_post", tx_busy, 1);
        wait_idle(3 * FRAME);
        exp_q = '{8'h81, 8'h42, 8'h7E};
        chk_rx();

`ifdef UART_BUFFERED_TX_PARITY_EN
        // 0x07: even parity bit is 1
        push1(8'h07);
        repeat (1 + 8 * 208 + 100) @(negedge clk);
        chk("p_bit7", uart_txd, 0);
        repeat (208) @(negedge clk);
        chk("p_parity", uart_txd, 1);
        repeat (208) @(negedge clk);
        chk("p_stop", uart_txd, 1);
        repeat (2288 - (1 + 10 * 208 + 100) - 1) @(negedge clk);
        chk("p_done", tx_done, 1);
        wait_idle(FRAME);
        exp_q = '{8'h07};
        chk_rx();
`endif

        // Reset during bit 3 of 0x3C with four bytes queued
        wr_valid = 1'b1;
        wr_data = 8'h3C; @(negedge clk);
        wr_data = 8'h11; @(negedge clk);
        wr_data = 8'h22; @(negedge clk);
        wr_data = 8'h33; @(negedge clk);
        wr_data = 8'h44; @(negedge clk);
        wr_valid = 1'b0;
        chk("r_count_4", fifo_count, 4);
        repeat (930) @(negedge clk);
        chk("r_bit3", uart_txd, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("r_async_txd", uart_txd, 1);
        chk("r_async_count", fifo_count, 0);
        chk("r_async_busy", tx_busy, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        done_cnt = 0;
        repeat (2 * FRAME) @(negedge clk);
        chk("r_post_busy", tx_busy, 0);
        chk("r_post_count", fifo_count, 0);
        chk("r_post_txd", uart_txd, 1);
        chk("r_post_done_cnt", done_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
